// File: rtl/descriptor_streamer_if.sv
// Valid/ready byte stream from the descriptor streamer to the UART transmitter.
interface descriptor_streamer_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_out, output byte_valid, input byte_ready);
  modport slave  (input byte_out, input byte_valid, output byte_ready);
endinterface

// File: rtl/descriptor_streamer.sv
// Reads keypoint descriptors back from the descriptor BRAM and emits them as
// framed bytes (0xA5 header + MSB-first histogram words, then 0x5A/count trailer).
//
// state   | meaning
// IDLE    | waiting for start; latches group count
// HEADER  | presenting 0xA5 frame header
// FETCH   | BRAM address driven, waiting out 2-cycle read latency
// SEND    | presenting histogram word bytes, MSB first
// TRAILER | presenting 0x5A, G[15:8], G[7:0]
// DONE    | one-cycle stream_done pulse
module descriptor_streamer #(
  parameter int NUMBER_DESCRIPTORS   = 4000,
  parameter int HIST_WIDTH           = 24,
  parameter int PATCHES_PER_KEYPOINT = 4,
  localparam int AW = $clog2(NUMBER_DESCRIPTORS)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start,
  input  logic [AW-1:0]         desc_count,
  output logic [AW-1:0]         desc_read_addr,
  input  logic [HIST_WIDTH-1:0] desc_read,
  descriptor_streamer_if.master bs,
  output logic                  busy,
  output logic                  stream_done
);

  localparam int BPW = HIST_WIDTH / 8;
  localparam int WW  = (PATCHES_PER_KEYPOINT > 1) ? $clog2(PATCHES_PER_KEYPOINT) : 1;
  localparam int CW  = (BPW > 3) ? $clog2(BPW) : 2;
  localparam logic [WW-1:0] LAST_WORD = WW'(PATCHES_PER_KEYPOINT - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FETCH,
    S_SEND,
    S_TRAILER,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [1:0]            rst_sync;
  logic                  rst_n;
  logic [AW-1:0]         g_new;
  logic [AW-1:0]         g_q;
  logic [AW-1:0]         group_q;
  logic [WW-1:0]         word_q;
  logic [1:0]            wait_cnt;
  logic [CW-1:0]         byte_cnt;
  logic [AW-1:0]         ptr_q;
  logic [AW-1:0]         addr_q;
  logic [HIST_WIDTH-1:0] shift_q;
  logic [15:0]           g16;
  logic [7:0]            byte_d;
  logic                  valid_d;
  logic                  xfer;

  // Async assert, synchronous release of the internal reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign g_new          = AW'(desc_count / PATCHES_PER_KEYPOINT);
  assign g16            = 16'(g_q);
  assign xfer           = valid_d & bs.byte_ready;
  assign bs.byte_out    = byte_d;
  assign bs.byte_valid  = valid_d;
  assign desc_read_addr = addr_q;
  assign busy           = (state != S_IDLE);
  assign stream_done    = (state == S_DONE);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    valid_d = 1'b0;
    byte_d  = 8'h00;
    unique case (state)
      S_IDLE: begin
        if (start) state_d = (g_new == '0) ? S_TRAILER : S_HEADER;
      end
      S_HEADER: begin
        valid_d = 1'b1;
        byte_d  = 8'hA5;
        if (bs.byte_ready) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (wait_cnt == 2'd2) state_d = S_SEND;
      end
      S_SEND: begin
        valid_d = 1'b1;
        byte_d  = shift_q[HIST_WIDTH-1 -: 8];
        if (bs.byte_ready && byte_cnt == LAST_BYTE) begin
          if (word_q != LAST_WORD)              state_d = S_FETCH;
          else if (group_q != g_q - AW'(1))     state_d = S_HEADER;
          else                                  state_d = S_TRAILER;
        end
      end
      S_TRAILER: begin
        valid_d = 1'b1;
        case (byte_cnt)
          CW'(0):  byte_d = 8'h5A;
          CW'(1):  byte_d = g16[15:8];
          default: byte_d = g16[7:0];
        endcase
        if (bs.byte_ready && byte_cnt == CW'(2)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Words are read strictly in order, so a linear pointer equals 4*group+word.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      g_q      <= '0;
      group_q  <= '0;
      word_q   <= '0;
      wait_cnt <= 2'd0;
      byte_cnt <= '0;
      ptr_q    <= '0;
      addr_q   <= '0;
      shift_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            g_q      <= g_new;
            group_q  <= '0;
            word_q   <= '0;
            byte_cnt <= '0;
            wait_cnt <= 2'd0;
            ptr_q    <= '0;
          end
        end
        S_FETCH: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_cnt == 2'd2) begin
            wait_cnt <= 2'd0;
            shift_q  <= desc_read;
            byte_cnt <= '0;
            ptr_q    <= ptr_q + AW'(1);
          end
        end
        S_SEND: begin
          if (xfer) begin
            shift_q  <= shift_q << 8;
            byte_cnt <= byte_cnt + CW'(1);
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              if (word_q != LAST_WORD) begin
                word_q <= word_q + WW'(1);
              end else begin
                word_q  <= '0;
                group_q <= group_q + AW'(1);
              end
            end
          end
        end
        S_TRAILER: begin
          if (xfer) byte_cnt <= byte_cnt + CW'(1);
        end
        default: ;
      endcase
      // Address is loaded on entry so it is stable for the whole FETCH window.
      if (state_d == S_FETCH && state != S_FETCH) addr_q <= ptr_q;
    end
  end

endmodule

// File: tb/tb_descriptor_streamer.sv
// Self-checking bench: byte-queue model of the framed stream, per-cycle compare
// against the DUT, plus literal expectations for the directed cases.
module tb_descriptor_streamer;
  localparam int AW = 12;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] desc_count = '0;
  logic [AW-1:0] desc_read_addr;
  logic [23:0]   desc_read;
  logic          busy;
  logic          stream_done;

  descriptor_streamer_if bs();

  descriptor_streamer dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .start          (start),
    .desc_count     (desc_count),
    .desc_read_addr (desc_read_addr),
    .desc_read      (desc_read),
    .bs             (bs),
    .busy           (busy),
    .stream_done    (stream_done)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // BRAM with 2-cycle read latency
  logic [23:0] mem [0:4095];
  logic [23:0] p1 = '0, p2 = '0;
  always @(posedge clk_in) begin
    p1 <= mem[desc_read_addr];
    p2 <= p1;
  end
  assign desc_read = p2;

  bit ready_mode = 1'b0;
  initial begin
    bs.byte_ready = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      bs.byte_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int lim = 1;
  int done_cnt = 0;
  int done_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: the whole expected byte stream computed from the framing rules.
  function automatic void build_exp(input int cnt);
    int g;
    logic [23:0] w;
    g = cnt / 4;
    exp_q.delete();
    for (int k = 0; k < g; k++) begin
      exp_q.push_back(8'hA5);
      for (int j = 0; j < 4; j++) begin
        w = mem[4*k + j];
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
      end
    end
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'((g >> 8) & 255));
    exp_q.push_back(8'(g & 255));
    lim = (g == 0) ? 1 : 4 * g;
  endfunction

  initial begin : cmp
    logic       prev_stall;
    logic       prev_done;
    logic [7:0] prev_byte;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_byte  = 8'h00;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", bs.byte_valid, 1);
          check("hold_byte", bs.byte_out, prev_byte);
        end
        if (prev_done) check("busy_after_done", busy, 0);
        if (bs.byte_valid && bs.byte_ready) begin
          got_q.push_back(bs.byte_out);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_byte: got %02h with none expected (t=%0t)", bs.byte_out, $time);
          end else begin
            check("stream_byte", bs.byte_out, exp_q.pop_front());
          end
        end
        if (busy) check("addr_range", 32'(desc_read_addr < AW'(lim)), 1);
        if (stream_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_stall = bs.byte_valid && !bs.byte_ready;
        prev_byte  = bs.byte_out;
        prev_done  = stream_done;
      end
    end
  end

  task automatic run_stream(input int cnt, input bit rnd, input bit dbl);
    int start_cyc;
    int g;
    int n_exp;
    g = cnt / 4;
    build_exp(cnt);
    n_exp = exp_q.size();
    got_q.delete();
    done_cnt = 0;
    ready_mode = rnd;
    @(posedge clk_in);
    #1;
    desc_count = AW'(cnt);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk_in);
    #1;
    start = 1'b0;
    if (dbl) begin
      repeat (10) @(posedge clk_in);
      #1;
      desc_count = AW'(8);
      start = 1'b1;
      @(posedge clk_in);
      #1;
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk_in);
    check("done_seen", 32'(done_cnt > 0), 1);
    // Cycles counted inclusively from the start cycle to the stream_done cycle.
    if (!rnd) check("done_latency", done_cyc - start_cyc + 1, 5 + 25 * g);
    repeat (40) @(posedge clk_in);
    check("done_once", done_cnt, 1);
    check("exp_drained", exp_q.size(), 0);
    check("byte_count", got_q.size(), n_exp);
    ready_mode = 1'b0;
  endtask

  logic [7:0] lit1 [16];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 24'h0;
    mem[0] = 24'h123456; mem[1] = 24'h789ABC; mem[2] = 24'hDEF012; mem[3] = 24'h345678;
    mem[4] = 24'hA1B2C3; mem[5] = 24'hD4E5F6; mem[6] = 24'h071829; mem[7] = 24'h3A4B5C;
    mem[8] = 24'hFFFFFF;
    lit1 = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE,
             8'hF0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h5A, 8'h00, 8'h01};

    #2;
    check("rst_addr", desc_read_addr, 0);
    check("rst_byte", bs.byte_out, 0);
    check("rst_valid", bs.byte_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", stream_done, 0);
    repeat (3) @(posedge clk_in);
    rst_n_in = 1'b1;
    repeat (4) @(posedge clk_in);

    // Empty descriptor set: trailer only
    run_stream(0, 1'b0, 1'b0);
    check("g0_len", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("g0_b0", got_q[0], 8'h5A);
      check("g0_b1", got_q[1], 8'h00);
      check("g0_b2", got_q[2], 8'h00);
    end

    // One keypoint, ready held high
    run_stream(4, 1'b0, 1'b0);
    check("t1_len", got_q.size(), 16);
    for (int i = 0; i < 16; i++)
      check("t1_byte", (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, lit1[i]);

    // Random backpressure, same byte sequence
    run_stream(4, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      check("rnd_byte", (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, lit1[i]);

    // Second start while busy is ignored
    run_stream(4, 1'b0, 1'b1);

    // Reset during the second byte of the first word
    build_exp(4);
    @(posedge clk_in);
    #1;
    desc_count = AW'(4);
    start = 1'b1;
    @(posedge clk_in);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk_in);
    #2;
    check("pre_rst_valid", bs.byte_valid, 1);
    check("pre_rst_byte", bs.byte_out, 8'h34);
    rst_n_in = 1'b0;
    #1;
    check("arst_addr", desc_read_addr, 0);
    check("arst_byte", bs.byte_out, 0);
    check("arst_valid", bs.byte_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", stream_done, 0);
    exp_q.delete();
    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    repeat (4) @(posedge clk_in);
    run_stream(4, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      check("post_rst_byte", (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, lit1[i]);

    // Nine words: two frames, word 8 never read
    run_stream(9, 1'b0, 1'b0);
    check("g2_len", got_q.size(), 29);
    if (got_q.size() == 29) begin
      check("g2_hdr2", got_q[13], 8'hA5);
      check("g2_w4b0", got_q[14], 8'hA1);
      check("g2_tr0", got_q[26], 8'h5A);
      check("g2_tr1", got_q[27], 8'h00);
      check("g2_tr2", got_q[28], 8'h02);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
